pc_sequencer: RTL and testbench

- Owns the 16-bit program counter and sequences instruction fetch from instruction memory using a req/ack handshake.
- Advances the PC by 2 per accepted fetch, holds the PC under pipeline stall, and redirects it on jump or taken branch, with a one-cycle flush pulse.
- Sits between the fetch stage and instruction memory.
- Embeds the team's standard PC+2 incrementer as its sequential-address source.

---
 rtl/risc_pkg.sv | 16 +
 rtl/pc_incrementer.sv | 18 +
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared constants for the fetch front end.
// ADDR_W   : program counter / instruction memory address width
// PC_INC   : byte step between sequential 16-bit instructions
// RESET_PC : default program counter value after reset
// ST_*     : 2-bit encoding of the PC sequencer state register
package risc_pkg;

   localparam int ADDR_W = 16;
   localparam int PC_INC = 2;
   localparam logic [15:0] RESET_PC = 16'h0000;

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/pc_incrementer.sv
// Standard sequential-address source: pc_next = pc + PC_INC, modulo 2^ADDR_W.
// Ports:
//   pc      in  ADDR_W  current program counter
//   pc_next out ADDR_W  address of the next sequential instruction
module pc_incrementer #(
   parameter int ADDR_W = risc_pkg::ADDR_W,
   parameter int PC_INC = risc_pkg::PC_INC
) (
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_next
);

   localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

   // Carry out of the top bit is dropped so the address wraps silently.
   assign pc_next = pc + INC;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction fetch sequencer.
// Issues req/ack fetches to instruction memory, advances the PC by PC_INC per
// accepted instruction, holds under stall and redirects on jump/taken branch.
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   stall                         fetch stage cannot accept a new instruction
//   branch_taken, branch_target   taken conditional branch and destination
//   jump, jump_target             unconditional jump and destination
//   imem_req, imem_addr, imem_ack instruction memory handshake
//   pc, pc_plus2                  current PC and PC + PC_INC
//   fetch_valid                   pulse: instruction at the old pc accepted
//   flush                         pulse: redirect taken, in-flight fetch dropped
module pc_sequencer #(
   parameter int                ADDR_W   = risc_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = risc_pkg::RESET_PC,
   parameter int                PC_INC   = risc_pkg::PC_INC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus2,
   output logic              fetch_valid,
   output logic              flush
);

   import risc_pkg::*;

   localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:1], 1'b0};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic              flush_q, flush_d;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_target;

   pc_incrementer #(
      .ADDR_W (ADDR_W),
      .PC_INC (PC_INC)
   ) u_inc (
      .pc      (pc_q),
      .pc_next (pc_plus2)
   );

   // Jump wins over a taken branch; the target is forced halfword-aligned.
   assign redirect        = jump | branch_taken;
   assign redirect_target = jump ? jump_target : branch_target;

   // Next-state logic. A redirect outranks an ack, which outranks a stall, so
   // an ack coinciding with a redirect is discarded rather than delivered.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_valid_d = 1'b0;
      flush_d       = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (redirect) begin
               pc_d    = {redirect_target[ADDR_W-1:1], 1'b0};
               flush_d = 1'b1;
            end else if (imem_ack) begin
               if (stall) begin
                  state_d = ST_HOLD;
               end else begin
                  fetch_valid_d = 1'b1;
                  pc_d          = pc_plus2;
               end
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_d    = {redirect_target[ADDR_W-1:1], 1'b0};
               flush_d = 1'b1;
               state_d = ST_FETCH;
            end else if (!stall) begin
               fetch_valid_d = 1'b1;
               pc_d          = pc_plus2;
               state_d       = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State and registered outputs; reset forces them immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC_ALIGNED;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         flush_q       <= flush_d;
      end
   end

   // Request is decoded from state only, so no input reaches it combinationally.
   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign fetch_valid = fetch_valid_q;
   assign flush       = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run compared against a behavioural model of the fetch rules.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, branch_taken, jump, imem_ack;
   logic [15:0] branch_target, jump_target;

   logic        imem_req, fetch_valid, flush;
   logic [15:0] imem_addr, pc, pc_plus2;

   logic        w_imem_req, w_fetch_valid, w_flush;
   logic [15:0] w_imem_addr, w_pc, w_pc_plus2;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] m_pc;
   bit          m_booting, m_holding, m_fv, m_flush;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .pc(pc), .pc_plus2(pc_plus2), .fetch_valid(fetch_valid), .flush(flush)
   );

   pc_sequencer #(.RESET_PC(16'hFFFC)) dut_wrap (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack),
      .pc(w_pc), .pc_plus2(w_pc_plus2), .fetch_valid(w_fetch_valid), .flush(w_flush)
   );

   // Model state mirrors the architectural rules: a PC, whether we are still
   // booting, and whether an accepted instruction is parked downstream.
   task automatic model_reset();
      m_pc      = 16'h0000;
      m_booting = 1'b1;
      m_holding = 1'b0;
      m_fv      = 1'b0;
      m_flush   = 1'b0;
   endtask

   task automatic tick();
      m_fv    = 1'b0;
      m_flush = 1'b0;
      if (m_booting) begin
         m_booting = 1'b0;
      end else if (jump || branch_taken) begin
         m_pc      = (jump ? jump_target : branch_target) & 16'hFFFE;
         m_flush   = 1'b1;
         m_holding = 1'b0;
      end else if (!m_holding) begin
         if (imem_ack && !stall) begin
            m_fv = 1'b1;
            m_pc = m_pc + 16'd2;
         end else if (imem_ack) begin
            m_holding = 1'b1;
         end
      end else if (!stall) begin
         m_fv      = 1'b1;
         m_pc      = m_pc + 16'd2;
         m_holding = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; branch_taken = 0; jump = 0; imem_ack = 0;
      branch_target = 16'h0000; jump_target = 16'h0000;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic go_to(input logic [15:0] target);
      idle_inputs();
      jump = 1'b1; jump_target = target;
      tick();
      jump = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #3;
      n_checks++; if (pc !== 16'h0000) $display("[TB] FAIL reset_pc: got %h want 0000", pc); else n_pass++;
      n_checks++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", imem_req); else n_pass++;
      n_checks++; if (fetch_valid !== 1'b0 || flush !== 1'b0) $display("[TB] FAIL reset_pulses: got fv=%b fl=%b want 0 0", fetch_valid, flush); else n_pass++;
      n_checks++; if (w_pc !== 16'hFFFC) $display("[TB] FAIL reset_wrap_pc: got %h want fffc", w_pc); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b0) $display("[TB] FAIL boot_req: got %b want 0", imem_req); else n_pass++;
      tick();
      n_checks++; if (imem_req !== 1'b1) $display("[TB] FAIL first_req: got %b want 1", imem_req); else n_pass++;
      n_checks++; if (imem_addr !== 16'h0000) $display("[TB] FAIL first_addr: got %h want 0000", imem_addr); else n_pass++;
      for (int i = 0; i < 3; i++) tick();
      n_checks++; if (pc !== 16'h0000 || imem_req !== 1'b1) $display("[TB] FAIL idle_wait: got pc=%h req=%b want 0000 1", pc, imem_req); else n_pass++;
   endtask

   task automatic test_stream();
      logic [15:0] exp_addr;
      imem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_addr = 16'(2 * i);
         n_checks++; if (imem_addr !== exp_addr) $display("[TB] FAIL stream_addr%0d: got %h want %h", i, imem_addr, exp_addr); else n_pass++;
         tick();
         n_checks++; if (fetch_valid !== 1'b1) $display("[TB] FAIL stream_fv%0d: got %b want 1", i, fetch_valid); else n_pass++;
      end
      imem_ack = 1'b0;
      n_checks++; if (pc !== 16'h0008) $display("[TB] FAIL stream_pc: got %h want 0008", pc); else n_pass++;
   endtask

   task automatic test_stall();
      go_to(16'h0004);
      n_checks++; if (flush !== 1'b1) $display("[TB] FAIL stall_setup_flush: got %b want 1", flush); else n_pass++;
      imem_ack = 1'b1; stall = 1'b1;
      tick();
      imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (imem_req !== 1'b0 || pc !== 16'h0004 || fetch_valid !== 1'b0) $display("[TB] FAIL stall_hold%0d: got req=%b pc=%h fv=%b want 0 0004 0", i, imem_req, pc, fetch_valid); else n_pass++;
         tick();
      end
      stall = 1'b0;
      tick();
      n_checks++; if (fetch_valid !== 1'b1 || pc !== 16'h0006) $display("[TB] FAIL stall_release: got fv=%b pc=%h want 1 0006", fetch_valid, pc); else n_pass++;
      tick();
      n_checks++; if (fetch_valid !== 1'b0 || imem_req !== 1'b1) $display("[TB] FAIL stall_after: got fv=%b req=%b want 0 1", fetch_valid, imem_req); else n_pass++;
   endtask

   task automatic test_redirect();
      go_to(16'h0010);
      jump = 1'b1; jump_target = 16'h1234;
      branch_taken = 1'b1; branch_target = 16'h0100;
      imem_ack = 1'b1;
      tick();
      idle_inputs();
      n_checks++; if (flush !== 1'b1 || fetch_valid !== 1'b0 || pc !== 16'h1234) $display("[TB] FAIL redirect_all: got fl=%b fv=%b pc=%h want 1 0 1234", flush, fetch_valid, pc); else n_pass++;
      tick();
      n_checks++; if (flush !== 1'b0) $display("[TB] FAIL flush_pulse: got %b want 0", flush); else n_pass++;
      jump = 1'b1; jump_target = 16'h1235;
      tick();
      jump = 1'b0;
      n_checks++; if (pc !== 16'h1234) $display("[TB] FAIL jump_align: got %h want 1234", pc); else n_pass++;
      branch_taken = 1'b1; branch_target = 16'h0101;
      tick();
      branch_taken = 1'b0;
      n_checks++; if (pc !== 16'h0100 || flush !== 1'b1) $display("[TB] FAIL branch_only: got pc=%h fl=%b want 0100 1", pc, flush); else n_pass++;
   endtask

   task automatic test_wrap();
      apply_reset();
      tick();
      n_checks++; if (w_imem_addr !== 16'hFFFC || w_imem_req !== 1'b1) $display("[TB] FAIL wrap_addr0: got %h req=%b want fffc 1", w_imem_addr, w_imem_req); else n_pass++;
      imem_ack = 1'b1;
      tick();
      n_checks++; if (w_imem_addr !== 16'hFFFE) $display("[TB] FAIL wrap_addr1: got %h want fffe", w_imem_addr); else n_pass++;
      n_checks++; if (w_pc_plus2 !== 16'h0000) $display("[TB] FAIL wrap_plus2: got %h want 0000", w_pc_plus2); else n_pass++;
      tick();
      imem_ack = 1'b0;
      n_checks++; if (w_imem_addr !== 16'h0000 || w_fetch_valid !== 1'b1) $display("[TB] FAIL wrap_addr2: got %h fv=%b want 0000 1", w_imem_addr, w_fetch_valid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      go_to(16'h0040);
      imem_ack = 1'b1; stall = 1'b1;
      tick();
      imem_ack = 1'b0;
      tick();
      n_checks++; if (imem_req !== 1'b0 || pc !== 16'h0040) $display("[TB] FAIL mid_hold: got req=%b pc=%h want 0 0040", imem_req, pc); else n_pass++;
      rst = 1'b1;
      model_reset();
      imem_ack = 1'b1;
      #2;
      n_checks++; if (pc !== 16'h0000 || imem_req !== 1'b0 || fetch_valid !== 1'b0) $display("[TB] FAIL mid_reset: got pc=%h req=%b fv=%b want 0000 0 0", pc, imem_req, fetch_valid); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      stall = 1'b0;
      tick();
      n_checks++; if (pc !== 16'h0000 || fetch_valid !== 1'b0 || imem_req !== 1'b1) $display("[TB] FAIL mid_boot_ack: got pc=%h fv=%b req=%b want 0000 0 1", pc, fetch_valid, imem_req); else n_pass++;
      imem_ack = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] exp_p2;
      for (int i = 0; i < 400; i++) begin
         stall         = ($urandom_range(0, 3) == 0);
         imem_ack      = $urandom_range(0, 1) != 0;
         jump          = ($urandom_range(0, 15) == 0);
         branch_taken  = ($urandom_range(0, 11) == 0);
         jump_target   = 16'($urandom);
         branch_target = 16'($urandom);
         tick();
         exp_p2 = m_pc + 16'd2;
         n_checks++;
         if (pc !== m_pc || imem_addr !== m_pc || pc_plus2 !== exp_p2 ||
             imem_req !== (!m_booting && !m_holding) || fetch_valid !== m_fv || flush !== m_flush)
            $display("[TB] FAIL random%0d: got pc=%h addr=%h p2=%h req=%b fv=%b fl=%b want pc=%h p2=%h req=%b fv=%b fl=%b",
                     i, pc, imem_addr, pc_plus2, imem_req, fetch_valid, flush,
                     m_pc, exp_p2, !m_booting && !m_holding, m_fv, m_flush);
         else n_pass++;
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
